// File: rtl/i2c_regbus_pkg.sv
// ---------------------------------------------------------------------------
// i2c_regbus_pkg
// Shared constants and types for the I2C / host register-bank arbiter.
//   ADDR_W, DATA_W : register bank address and data widths
//   arbState_t     : arbiter FSM state encoding
//   slotReq_t      : contents of the pending I2C request slot
// ---------------------------------------------------------------------------
package i2c_regbus_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACC_I2C   = 3'd1,
    ACC_HOST  = 3'd2,
    RD_WAIT   = 3'd3,
    HOST_DONE = 3'd4
  } arbState_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } slotReq_t;

endpackage

// File: rtl/i2c_req_slot.sv
// ---------------------------------------------------------------------------
// i2c_req_slot
// Single-entry holding slot for I2C strobes.
//   clk, rst        : clock, synchronous active-high reset
//   wrStb, rdStb    : one-cycle strobes from the I2C slave engine
//   addr, wdata     : strobe address / write data
//   grant           : arbiter is consuming the slot this cycle
//   vld             : slot holds a pending request
//   req             : pending request (type, address, data)
//   ovf             : one-cycle pulse, a strobe was dropped
// A strobe is accepted when the slot is empty or is being granted in the
// same cycle. A simultaneous write+read keeps the write and drops the read.
// ---------------------------------------------------------------------------
module i2c_req_slot
  import i2c_regbus_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wrStb,
  input  logic              rdStb,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              grant,
  output logic              vld,
  output slotReq_t          req,
  output logic              ovf
);

  logic anyStb;
  logic accept;

  assign anyStb = wrStb | rdStb;
  assign accept = anyStb & (~vld | grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      ovf <= 1'b0;
    end else begin
      // one pulse covers both the write+read collision and a full slot
      ovf <= (wrStb & rdStb) | (anyStb & ~accept);
      if (accept) begin
        vld <= 1'b1;
      end else if (grant) begin
        vld <= 1'b0;
      end
    end
  end

  // payload is qualified by vld, so it needs no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      req.we    <= wrStb;
      req.addr  <= addr;
      req.wdata <= wdata;
    end
  end

endmodule

// File: rtl/i2c_regbus_arb.sv
// ---------------------------------------------------------------------------
// i2c_regbus_arb
// Arbitrates a single-port register bank between an I2C slave engine and a
// local host.
//   clk, rst                         : clock, synchronous active-high reset
//   i2c_wr_stb, i2c_rd_stb           : I2C one-cycle strobes
//   i2c_addr, i2c_wdata              : I2C address / write data
//   i2c_rdata, i2c_rvld              : I2C read data and its valid pulse
//   i2c_ovf                          : pulse, an I2C strobe was dropped
//   host_req, host_we                : host request (held until ack), dir
//   host_addr, host_wdata            : host address / write data
//   host_ack, host_rdata             : completion pulse and read data
//   bank_en, bank_we                 : bank access / write enables
//   bank_addr, bank_wdata, bank_rdata: bank address, write and read data
// Optional macro ARB_ROUND_ROBIN_EN: on an I2C/host tie the source that did
// not win the previous tie is served; without it I2C always wins ties.
// Bank read data arrives one cycle after the access cycle (RD_WAIT) and is
// registered into the requester's read-data output at the end of RD_WAIT.
// ---------------------------------------------------------------------------
module i2c_regbus_arb
  import i2c_regbus_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i2c_wr_stb,
  input  logic              i2c_rd_stb,
  input  logic [ADDR_W-1:0] i2c_addr,
  input  logic [DATA_W-1:0] i2c_wdata,
  output logic [DATA_W-1:0] i2c_rdata,
  output logic              i2c_rvld,
  output logic              i2c_ovf,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              bank_en,
  output logic              bank_we,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [DATA_W-1:0] bank_wdata,
  input  logic [DATA_W-1:0] bank_rdata
);

  arbState_t state;
  logic      srcHost;
  logic      slotVld;
  slotReq_t  slotReq;
  logic      i2cFirst;
  logic      pickI2c;
  logic      pickHost;

`ifdef ARB_ROUND_ROBIN_EN
  logic lastServed;  // 1: I2C won the previous tie, 0: host did
  assign i2cFirst = ~lastServed;
`else
  assign i2cFirst = 1'b1;
`endif

  assign pickI2c  = (state == IDLE) & slotVld & (~host_req | i2cFirst);
  assign pickHost = (state == IDLE) & host_req & ~pickI2c;

  i2c_req_slot u_slot (
    .clk   (clk),
    .rst   (rst),
    .wrStb (i2c_wr_stb),
    .rdStb (i2c_rd_stb),
    .addr  (i2c_addr),
    .wdata (i2c_wdata),
    .grant (pickI2c),
    .vld   (slotVld),
    .req   (slotReq),
    .ovf   (i2c_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      srcHost    <= 1'b0;
      bank_en    <= 1'b0;
      bank_we    <= 1'b0;
      bank_addr  <= '0;
      bank_wdata <= '0;
      i2c_rdata  <= '0;
      i2c_rvld   <= 1'b0;
      host_rdata <= '0;
      host_ack   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      lastServed <= 1'b0;
`endif
    end else begin
      bank_en  <= 1'b0;
      bank_we  <= 1'b0;
      i2c_rvld <= 1'b0;
      host_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (pickI2c) begin
            state      <= ACC_I2C;
            srcHost    <= 1'b0;
            bank_en    <= 1'b1;
            bank_we    <= slotReq.we;
            bank_addr  <= slotReq.addr;
            bank_wdata <= slotReq.wdata;
          end else if (pickHost) begin
            state      <= ACC_HOST;
            srcHost    <= 1'b1;
            bank_en    <= 1'b1;
            bank_we    <= host_we;
            bank_addr  <= host_addr;
            bank_wdata <= host_wdata;
          end
        end
        // bank_we still holds the direction of the access in flight
        ACC_I2C: state <= bank_we ? IDLE : RD_WAIT;
        ACC_HOST: begin
          if (bank_we) begin
            state    <= HOST_DONE;
            host_ack <= 1'b1;
          end else begin
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (srcHost) begin
            host_rdata <= bank_rdata;
            host_ack   <= 1'b1;
            state      <= HOST_DONE;
          end else begin
            i2c_rdata <= bank_rdata;
            i2c_rvld  <= 1'b1;
            state     <= IDLE;
          end
        end
        // ack cycle: no grant, so a still-high host_req is a fresh request
        HOST_DONE: state <= IDLE;
        default:   state <= IDLE;
      endcase
`ifdef ARB_ROUND_ROBIN_EN
      if ((state == IDLE) && slotVld && host_req) begin
        lastServed <= pickI2c;
      end
`endif
    end
  end

endmodule

// File: tb/tb_i2c_regbus_arb.sv
module tb_i2c_regbus_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       i2c_wr_stb, i2c_rd_stb;
  logic [7:0] i2c_addr, i2c_wdata, i2c_rdata;
  logic       i2c_rvld, i2c_ovf;
  logic       host_req, host_we;
  logic [7:0] host_addr, host_wdata, host_rdata;
  logic       host_ack;
  logic       bank_en, bank_we;
  logic [7:0] bank_addr, bank_wdata, bank_rdata;

  always #5 clk = ~clk;

  i2c_regbus_arb dut (
    .clk        (clk),
    .rst        (rst),
    .i2c_wr_stb (i2c_wr_stb),
    .i2c_rd_stb (i2c_rd_stb),
    .i2c_addr   (i2c_addr),
    .i2c_wdata  (i2c_wdata),
    .i2c_rdata  (i2c_rdata),
    .i2c_rvld   (i2c_rvld),
    .i2c_ovf    (i2c_ovf),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .bank_en    (bank_en),
    .bank_we    (bank_we),
    .bank_addr  (bank_addr),
    .bank_wdata (bank_wdata),
    .bank_rdata (bank_rdata)
  );

  // register bank: read data valid the cycle after the access, noise otherwise
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (bank_en && bank_we) mem[bank_addr] <= bank_wdata;
    if (bank_en && !bank_we) bank_rdata <= mem[bank_addr];
    else bank_rdata <= 8'($urandom);
  end

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] refMem [256];
  bit         written [256];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [63:0] allOut();
    return {28'd0, i2c_rdata, i2c_rvld, i2c_ovf, host_ack, host_rdata,
            bank_en, bank_we, bank_addr, bank_wdata};
  endfunction

  task automatic strobe(input logic wr, input logic rd, input logic [7:0] a, input logic [7:0] d);
    i2c_wr_stb = wr;
    i2c_rd_stb = rd;
    i2c_addr   = a;
    i2c_wdata  = d;
  endtask

  task automatic clrStb();
    i2c_wr_stb = 1'b0;
    i2c_rd_stb = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    clrStb();
    host_req = 1'b0;
    step();
    step();
    chk("rstOut", allOut(), 64'd0);
    rst = 1'b0;
  endtask

  // one host transfer from an idle bus; checks ack latency and read data
  task automatic hostOp(input logic we, input logic [7:0] a, input logic [7:0] d, input string tag);
    int   lat = 0;
    logic got = 1'b0;
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = a;
    host_wdata = d;
    for (int k = 1; k <= 20 && !got; k++) begin
      step();
      if (host_ack) begin
        got = 1'b1;
        lat = k;
      end
    end
    host_req = 1'b0;
    chk({tag, "Ack"}, got, 1);
    if (got) begin
      chk({tag, "Lat"}, lat, we ? 2 : 3);
      if (!we) chk({tag, "Data"}, host_rdata, refMem[a]);
      else refMem[a] = d;
    end
    step();
  endtask

  // I2C write 0x08 and host read 0x04 pending together in one IDLE cycle
  task automatic tieRun(input logic expHostFirst, input string tag);
    logic [7:0] order [2];
    int         n = 0;
    int         acks = 0;
    order[0] = 8'h00;
    order[1] = 8'h00;
    strobe(1'b1, 1'b0, 8'h08, 8'hC3);
    step();
    clrStb();
    host_req   = 1'b1;
    host_we    = 1'b0;
    host_addr  = 8'h04;
    host_wdata = 8'h00;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bank_en) begin
        if (n < 2) order[n] = bank_addr;
        n++;
      end
      if (host_ack) begin
        acks++;
        chk({tag, "HostData"}, host_rdata, refMem[8'h04]);
        host_req = 1'b0;
      end
    end
    refMem[8'h08] = 8'hC3;
    chk({tag, "Accesses"}, n, 2);
    chk({tag, "Acks"}, acks, 1);
    chk({tag, "First"}, order[0], expHostFirst ? 8'h04 : 8'h08);
    chk({tag, "Second"}, order[1], expHostFirst ? 8'h08 : 8'h04);
  endtask

  // random-phase reference state
  logic       pWr, pRd, sWe, slotOcc;
  logic [7:0] pA, pD, sAddr, sData;
  logic       hostActive, hostGranted, hWe;
  logic [7:0] hAddr, hData, hostExp, rvldData, lastI2c, lastHost;
  int         rvldDue, hostAckDue, slotAge, hostAge;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clrStb();
    i2c_addr = 8'h00; i2c_wdata = 8'h00;
    host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
    doReset();

    // single I2C write
    strobe(1'b1, 1'b0, 8'h10, 8'hA5);
    step();
    clrStb();
    chk("wrOvf", i2c_ovf, 0);
    chk("wrEarly", bank_en, 0);
    step();
    chk("wrBank", {bank_en, bank_we, bank_addr, bank_wdata}, {1'b1, 1'b1, 8'h10, 8'hA5});
    refMem[8'h10] = 8'hA5;
    step();
    chk("wrOnce", {bank_en, bank_we}, 0);
    step();

    // I2C read latency: preload 0x20, then read it back
    strobe(1'b1, 1'b0, 8'h20, 8'h3C);
    step();
    clrStb();
    step();
    step();
    refMem[8'h20] = 8'h3C;
    strobe(1'b0, 1'b1, 8'h20, 8'h00);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) begin
        clrStb();
        chk("rdOvf", i2c_ovf, 0);
      end
      chk("rdRvld", i2c_rvld, k == 4);
      if (k == 4) chk("rdData", i2c_rdata, 8'h3C);
    end

    // write and read strobes together: write kept, read dropped
    strobe(1'b1, 1'b1, 8'h30, 8'h77);
    step();
    clrStb();
    chk("dblOvf", i2c_ovf, 1);
    step();
    chk("dblBank", {bank_en, bank_we, bank_addr, bank_wdata}, {1'b1, 1'b1, 8'h30, 8'h77});
    refMem[8'h30] = 8'h77;
    step();
    chk("dblNoRd", {i2c_ovf, bank_en}, 0);
    step();

    // strobe in the slot's grant cycle is accepted
    strobe(1'b1, 1'b0, 8'h31, 8'h11);
    step();
    strobe(1'b1, 1'b0, 8'h32, 8'h22);
    step();
    clrStb();
    chk("gntOvf", i2c_ovf, 0);
    chk("gntBank1", {bank_en, bank_addr, bank_wdata}, {1'b1, 8'h31, 8'h11});
    step();
    step();
    chk("gntBank2", {bank_en, bank_addr, bank_wdata}, {1'b1, 8'h32, 8'h22});
    step();

    hostOp(1'b1, 8'h04, 8'h5A, "hWr");

    // ties
    tieRun(1'b0, "tie1");
`ifdef ARB_ROUND_ROBIN_EN
    tieRun(1'b1, "tie2");
`else
    tieRun(1'b0, "tie2");
`endif

    // two I2C strobes during a host read: second one lands in HOST_DONE
    begin
      int ovfCnt = 0, ovfCyc = 0, n40 = 0, n41 = 0, acks = 0;
      for (int k = 0; k < 14; k++) begin
        if (k == 0) begin
          host_req = 1'b1; host_we = 1'b0; host_addr = 8'h04;
        end
        if (k == 1) strobe(1'b1, 1'b0, 8'h40, 8'h01);
        if (k == 2) clrStb();
        if (k == 3) strobe(1'b1, 1'b0, 8'h41, 8'h02);
        if (k == 4) clrStb();
        step();
        if (i2c_ovf) begin
          ovfCnt++;
          ovfCyc = k + 1;
        end
        if (bank_en && bank_addr == 8'h40) n40++;
        if (bank_en && bank_addr == 8'h41) n41++;
        if (host_ack) begin
          acks++;
          host_req = 1'b0;
        end
      end
      refMem[8'h40] = 8'h01;
      chk("ovfCount", ovfCnt, 1);
      chk("ovfCycle", ovfCyc, 4);
      chk("ovfKept", n40, 1);
      chk("ovfDropped", n41, 0);
      chk("ovfHostAck", acks, 1);
    end

    // reset in RD_WAIT of a host read
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h04;
    step();
    step();
    chk("rstPreAck", host_ack, 0);
    rst = 1'b1;
    host_req = 1'b0;
    step();
    chk("rstAll", allOut(), 64'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rstNoAck", host_ack, 0);
    end
    hostOp(1'b0, 8'h04, 8'h00, "reissue");

    // randomized traffic against a transaction-level model
    doReset();
    for (int i = 0; i < 256; i++) written[i] = 1'b0;
    pWr = 1'b0; pRd = 1'b0; pA = 8'h00; pD = 8'h00;
    slotOcc = 1'b0; sWe = 1'b0; sAddr = 8'h00; sData = 8'h00;
    hostActive = 1'b0; hostGranted = 1'b0; hWe = 1'b0; hAddr = 8'h00; hData = 8'h00;
    hostExp = 8'h00; rvldData = 8'h00; lastI2c = 8'h00; lastHost = 8'h00;
    rvldDue = -1; hostAckDue = -1; slotAge = 0; hostAge = 0;
    for (int n = 0; n < 3000; n++) begin
      logic iG, hG, occOld, expOvf, rvExp, ackExp;
      int   r;
      // observe: I2C addresses are < 0x80, host addresses >= 0x80
      iG = bank_en && !bank_addr[7];
      hG = bank_en && bank_addr[7];
      chk("rndWeNoEn", bank_we && !bank_en, 0);
      occOld = slotOcc;
      expOvf = (pWr && pRd) || ((pWr || pRd) && occOld && !iG);
      chk("rndOvf", i2c_ovf, expOvf);
      if (iG) begin
        chk("rndI2cOcc", occOld, 1);
        chk("rndI2cReq", {bank_we, bank_addr}, {sWe, sAddr});
        if (bank_we) begin
          chk("rndI2cWdata", bank_wdata, sData);
          refMem[bank_addr] = bank_wdata;
          written[bank_addr] = 1'b1;
        end else begin
          rvldDue = cyc + 2;
          rvldData = refMem[bank_addr];
        end
        slotOcc = 1'b0;
      end
      if ((pWr || pRd) && (!occOld || iG)) begin
        slotOcc = 1'b1; sWe = pWr; sAddr = pA; sData = pD; slotAge = 0;
      end
      if (hG) begin
        chk("rndHostReq", {hostActive && !hostGranted, bank_we, bank_addr}, {1'b1, hWe, hAddr});
        hostGranted = 1'b1;
        hostAckDue = cyc + (hWe ? 1 : 2);
        if (hWe) begin
          chk("rndHostWdata", bank_wdata, hData);
          refMem[bank_addr] = bank_wdata;
          written[bank_addr] = 1'b1;
        end else begin
          hostExp = refMem[bank_addr];
        end
      end
      rvExp = (cyc == rvldDue);
      chk("rndRvld", i2c_rvld, rvExp);
      if (rvExp) lastI2c = rvldData;
      chk("rndI2cRdata", i2c_rdata, lastI2c);
      ackExp = hostActive && hostGranted && (cyc == hostAckDue);
      chk("rndHostAck", host_ack, ackExp);
      if (ackExp && !hWe) lastHost = hostExp;
      chk("rndHostRdata", host_rdata, lastHost);
      if (ackExp) begin
        hostActive = 1'b0;
        host_req = 1'b0;
      end
      if (slotOcc) slotAge++;
      if (slotAge > 60) begin
        chk("rndSlotStuck", slotAge, 60);
        slotOcc = 1'b0;
        slotAge = 0;
      end
      if (hostActive) hostAge++;
      if (hostAge > 60) begin
        chk("rndHostStuck", hostAge, 60);
        hostActive = 1'b0;
        host_req = 1'b0;
        hostAge = 0;
      end
      // drive next cycle
      r = $urandom_range(19);
      pA = {4'h0, 4'($urandom)};
      pD = 8'($urandom);
      pWr = (r <= 1) || (r == 4);
      pRd = (r == 2) || (r == 3) || (r == 4);
      if (pRd && !pWr && !written[pA]) begin
        pWr = 1'b1;
        pRd = 1'b0;
      end
      strobe(pWr, pRd, pA, pD);
      if (!hostActive && $urandom_range(3) == 0) begin
        hWe = 1'($urandom_range(1));
        hAddr = 8'h80 | {4'h0, 4'($urandom)};
        hData = 8'($urandom);
        if (!hWe && !written[hAddr]) hWe = 1'b1;
        host_req = 1'b1;
        host_we = hWe;
        host_addr = hAddr;
        host_wdata = hData;
        hostActive = 1'b1;
        hostGranted = 1'b0;
        hostAge = 0;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_regbus_arb.md
I2C_REGBUS_ARB -- requirements
Module: i2c_regbus_arb

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 i2c_wr_stb  in  1  one-cycle write strobe from the I2C slave engine.
REQ-004 i2c_rd_stb  in  1  one-cycle read strobe from the I2C slave engine.
REQ-005 i2c_addr  in  8  I2C register address, valid with either strobe.
REQ-006 i2c_wdata  in  8  I2C write data, valid with i2c_wr_stb.
REQ-007 i2c_rdata  out  8  read data returned to the I2C engine.
REQ-008 i2c_rvld  out  1  one-cycle pulse; i2c_rdata is valid.
REQ-009 i2c_ovf  out  1  one-cycle pulse; an I2C strobe was dropped.
REQ-010 host_req  in  1  local host request, held until host_ack.
REQ-011 host_we  in  1  host write (1) or read (0); stable while host_req is high.
REQ-012 host_addr / host_wdata  in  8 / 8  host address and write data; stable while host_req is high.
REQ-013 host_ack  out  1  one-cycle completion pulse.
REQ-014 host_rdata  out  8  host read data, valid with host_ack on reads.
REQ-015 bank_en / bank_we  out  1 / 1  shared single-port register-bank access and write enables.
REQ-016 bank_addr / bank_wdata  out  8 / 8  shared bank address and write data.
REQ-017 bank_rdata  in  8  bank read data, valid one cycle after a read access.

Function
REQ-018 The block SHALL capture any I2C strobe (type, address, data) into a single pending slot at the clock edge where the strobe is sampled.
REQ-019 If a strobe arrives while the slot is occupied and is not being granted that cycle, the block SHALL drop it and pulse i2c_ovf; a strobe arriving in the slot's grant cycle SHALL be accepted.
REQ-020 If i2c_wr_stb and i2c_rd_stb are sampled high together, the block SHALL capture the write, drop the read and pulse i2c_ovf.
REQ-021 The FSM SHALL use the states IDLE, ACC_I2C, ACC_HOST, RD_WAIT and HOST_DONE.
REQ-022 In IDLE with only one source pending, the block SHALL grant that source in the next cycle.
REQ-023 In IDLE with both the I2C slot and host_req pending, the block SHALL grant I2C (fixed priority, no macro).
REQ-024 In ACC_I2C or ACC_HOST, the block SHALL assert bank_en for exactly one cycle, with bank_we, bank_addr and bank_wdata driven from the granted source.
REQ-025 A write from ACC_I2C SHALL go to IDLE.
REQ-026 A write from ACC_HOST SHALL go to HOST_DONE, which pulses host_ack and then returns to IDLE.
REQ-027 A read SHALL pass through RD_WAIT, register bank_rdata into i2c_rdata or host_rdata, and pulse i2c_rvld or host_ack in the following cycle.
REQ-028 I2C read latency SHALL be 4 cycles from the strobe cycle to i2c_rvld when the bus is uncontended.
REQ-029 The block SHALL never regrant host in the host_ack cycle; host_req still high the cycle after host_ack SHALL count as a new request.
REQ-030 Outside a grant, bank_en and bank_we SHALL be 0; i2c_rdata and host_rdata SHALL hold their last value.

Reset
REQ-031 On rst, the block SHALL go to IDLE, clear the pending slot and the priority flag, and zero all outputs, including i2c_rdata and host_rdata.
REQ-032 Reset mid-access SHALL abandon the access with no ack or rvld; host must reissue its request.

Configuration
REQ-033 When ARB_ROUND_ROBIN_EN is defined, a last_served flag SHALL alternate priority on ties, so the source not served last wins.
REQ-034 When ARB_ROUND_ROBIN_EN is undefined, the block SHALL use fixed I2C priority as in REQ-023, and the flag SHALL not exist.

Structure
REQ-035 Package i2c_regbus_pkg SHALL hold the FSM state encoding and the ADDR_W=8 and DATA_W=8 constants.
REQ-036 Sub-module i2c_req_slot SHALL implement the pending slot, capture rules and overflow pulse; arbitration and FSM stay in the top module.

Verification
REQ-037 Scenario: I2C write strobe, addr 0x10, data 0xA5 -> one bank_en/bank_we cycle with 0x10/0xA5, i2c_ovf=0.
REQ-038 Scenario: I2C read strobe at 0x20, bank returns 0x3C -> i2c_rvld with i2c_rdata=0x3C exactly 4 cycles after the strobe.
REQ-039 Scenario: host read 0x04 and I2C write 0x08 pending in the same cycle -> I2C access first, then host access.
REQ-040 Scenario: repeat REQ-039 twice with ARB_ROUND_ROBIN_EN defined -> second tie goes to host first.
REQ-041 Scenario: two I2C strobes two cycles apart during a host read -> second strobe dropped, i2c_ovf pulses once.
REQ-042 Scenario: rst asserted in RD_WAIT of a host read -> no host_ack, all outputs 0; reissued request completes normally.
